tile_reader: RTL and testbench

//  Transmit side of the row-router broadcast bus. Sweeps one tile of the input

---
 rtl/tile_reader_pkg.sv | 16 +
 rtl/rd_delay_line.sv | 31 +++
 rtl/tile_reader.sv | 137 +++++++++++++
 tb/tb_tile_reader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tile_reader_pkg.sv
// Shared types for the tile reader (broadcast transmit side of the row-router bus).
package tile_reader_pkg;

  typedef enum logic [1:0] {
    TR_IDLE,
    TR_SWEEP,
    TR_DRAIN,
    TR_DONE
  } tr_state_e;

  // Modulo-2^W address add used for tile base + offset.
  function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/rd_delay_line.sv
// Fixed-depth shift register aligning issued read tags with SRAM read data.
module rd_delay_line #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; reset and clear flush all in-flight entries.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_reader.sv
// Sweeps one SRAM tile repeatedly and broadcasts {valid, addr, data} to the row
// routers until they all report done, or until the sweep limit aborts the tile.
module tile_reader
  import tile_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_SWEEPS = 15
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic                            i_reg_clear,
  input  logic                            i_start,
  input  logic [ADDR_WIDTH-1:0]           i_start_addr,
  input  logic [ADDR_WIDTH-1:0]           i_tile_len,
  input  logic                            i_stall,
  input  logic                            i_route_done,
  output logic                            o_sram_ren,
  output logic [ADDR_WIDTH-1:0]           o_sram_addr,
  input  logic [DATA_WIDTH-1:0]           i_sram_rdata,
  output logic                            o_valid_addr,
  output logic [ADDR_WIDTH-1:0]           o_addr,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_timeout,
  output logic [$clog2(MAX_SWEEPS+1)-1:0] o_sweep_count
);

  localparam int unsigned CountW = $clog2(MAX_SWEEPS + 1);
  localparam int unsigned DrainW = $clog2(RD_LATENCY + 1);

  tr_state_e             state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [CountW-1:0]     count_q;
  logic [DrainW-1:0]     drain_q;
  logic                  timeout_q;

  logic                  issue;
  logic                  last_word;
  logic                  hit_limit;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  stage_valid;
  logic [ADDR_WIDTH-1:0] stage_addr;

  // Issue decision: route_done is checked first and suppresses the read.
  always_comb begin
    issue     = (state_q == TR_SWEEP) && !i_route_done && !i_stall;
    last_word = (idx_q == len_q - ADDR_WIDTH'(1));
    hit_limit = last_word && (count_q == CountW'(MAX_SWEEPS - 1));
    rd_addr   = issue ? ADDR_WIDTH'(wrap_add(16'(base_q), 16'(idx_q))) : '0;
  end

  // Tile FSM plus index, sweep counter, drain counter and sticky timeout.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_q   <= TR_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        TR_IDLE: begin
          if (i_start) begin
            base_q    <= i_start_addr;
            len_q     <= i_tile_len;
            idx_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            state_q   <= (i_tile_len == '0) ? TR_DONE : TR_SWEEP;
          end
        end
        TR_SWEEP: begin
          if (i_route_done) begin
            drain_q <= '0;
            state_q <= TR_DRAIN;
          end else if (!i_stall) begin
            if (last_word) begin
              idx_q <= '0;
              if (count_q != CountW'(MAX_SWEEPS)) begin
                count_q <= count_q + CountW'(1);
              end
              if (hit_limit) begin
                timeout_q <= 1'b1;
                drain_q   <= '0;
                state_q   <= TR_DRAIN;
              end
            end else begin
              idx_q <= idx_q + ADDR_WIDTH'(1);
            end
          end
        end
        TR_DRAIN: begin
          // Stay long enough for the last issued read to reach the bus.
          if (drain_q == DrainW'(RD_LATENCY - 1)) begin
            state_q <= TR_DONE;
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        TR_DONE: state_q <= TR_IDLE;
        default: state_q <= TR_IDLE;
      endcase
    end
  end

  rd_delay_line #(
    .WIDTH(1 + ADDR_WIDTH),
    .DEPTH(RD_LATENCY)
  ) u_rd_delay_line (
    .clk_i  (i_clk),
    .rst_ni (i_nrst),
    .clear_i(i_reg_clear),
    .d_i    ({issue, rd_addr}),
    .q_o    ({stage_valid, stage_addr})
  );

  // Outputs; data is zeroed when not valid so an idle bus reads all-zero.
  always_comb begin
    o_sram_ren    = issue;
    o_sram_addr   = rd_addr;
    o_valid_addr  = stage_valid & ~i_stall;
    o_addr        = stage_addr;
    o_data        = o_valid_addr ? i_sram_rdata : '0;
    o_busy        = (state_q != TR_IDLE);
    o_done        = (state_q == TR_DONE);
    o_timeout     = timeout_q;
    o_sweep_count = count_q;
  end

endmodule

// File: tb/tb_tile_reader.sv
// Randomised directed bench for tile_reader against a word-count based reference model.
module tb_tile_reader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int L  = 2;
  localparam int MS = 3;
  localparam int CW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] tile_len = '0;
  logic          stall = 1'b0;
  logic          rdone = 1'b0;
  logic          sram_ren;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          valid_addr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] sweep_count;

  always #5 clk = ~clk;

  tile_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(L),
    .MAX_SWEEPS(MS)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_reg_clear  (clr),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_tile_len   (tile_len),
    .i_stall      (stall),
    .i_route_done (rdone),
    .o_sram_ren   (sram_ren),
    .o_sram_addr  (sram_addr),
    .i_sram_rdata (sram_rdata),
    .o_valid_addr (valid_addr),
    .o_addr       (addr),
    .o_data       (data),
    .o_busy       (busy),
    .o_done       (done),
    .o_timeout    (timeout),
    .o_sweep_count(sweep_count)
  );

  // SRAM model: mem[a] = a ^ 8'hA5, read data L cycles after the address.
  logic [AW-1:0] sram_pipe [L];
  always @(posedge clk) begin
    sram_pipe[0] <= sram_addr;
    for (int i = 1; i < L; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign sram_rdata = DW'(sram_pipe[L-1]) ^ 8'hA5;

  // Reference model: tile progress is the total number of words issued.
  int m_mode = 0;  // 0 idle, 1 issuing, 2 draining, 3 done pulse
  int m_base = 0, m_len = 0, m_n = 0, m_drain = 0;
  bit m_to = 0;
  int iss_t[$];
  int iss_a[$];
  int cyc = 0;

  int vectors = 0;
  int misc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      misc++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit st, input int sa, input int ln, input bit sl, input bit rd,
                      input bit cl, input bit rn, input bit do_chk);
    bit e_ren, due, e_val;
    int e_sa, e_addr, e_data, e_cnt;
    @(negedge clk);
    start = st; start_addr = AW'(sa); tile_len = AW'(ln);
    stall = sl; rdone = rd; clr = cl; nrst = rn;
    #1;
    e_ren  = (m_mode == 1) && !rd && !sl;
    e_sa   = e_ren ? (m_base + m_n % m_len) % (1 << AW) : 0;
    due    = (iss_t.size() > 0) && (iss_t[0] + L == cyc);
    e_addr = due ? iss_a[0] : 0;
    e_val  = due && !sl;
    e_data = e_val ? ((e_addr ^ 'hA5) & 'hFF) : 0;
    e_cnt  = (m_len == 0) ? 0 : ((m_n / m_len > MS) ? MS : m_n / m_len);
    if (do_chk) begin
      check("sram_ren", 32'(sram_ren), 32'(e_ren));
      check("sram_addr", 32'(sram_addr), 32'(e_sa));
      check("valid_addr", 32'(valid_addr), 32'(e_val));
      check("bcast_addr", 32'(addr), 32'(e_addr));
      check("bcast_data", 32'(data), 32'(e_data));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("done", 32'(done), 32'(m_mode == 3));
      check("timeout", 32'(timeout), 32'(m_to));
      check("sweep_count", 32'(sweep_count), 32'(e_cnt));
    end
    @(posedge clk);
    if (due) begin
      void'(iss_t.pop_front());
      void'(iss_a.pop_front());
    end
    if (!rn || cl) begin
      m_mode = 0; m_n = 0; m_to = 0; m_drain = 0;
      iss_t.delete(); iss_a.delete();
    end else begin
      case (m_mode)
        0: if (st) begin
          m_base = sa % (1 << AW); m_len = ln % (1 << AW); m_n = 0; m_to = 0;
          m_mode = (m_len == 0) ? 3 : 1;
        end
        1: if (rd) begin
          m_mode = 2; m_drain = L;
        end else if (!sl) begin
          iss_t.push_back(cyc);
          iss_a.push_back(e_sa);
          m_n++;
          if (m_n % m_len == 0 && m_n / m_len == MS) begin
            m_to = 1; m_mode = 2; m_drain = L;
          end
        end
        2: begin
          m_drain--;
          if (m_drain == 0) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
    cyc++;
  endtask

  // One tile: start pulse, then random stall / stray starts until the model idles.
  task automatic run_tile(input int base, input int len, input int rdone_at, input int stall_pct,
                          input int clr_at);
    bit fin = 0;
    step(1, base, len, 0, 0, 0, 1, 1);
    for (int k = 1; k < 400 && !fin; k++) begin
      step(($urandom % 10) == 0, $urandom, $urandom, ($urandom % 100) < stall_pct,
           (rdone_at >= 0) && (k >= rdone_at), k == clr_at, 1, 1);
      fin = (m_mode == 0);
    end
    vectors++;
    assert (fin)
    else begin
      misc++;
      $error("FAIL tile_budget observed=busy expected=idle within 400 cycles");
    end
    // Idle cycle with stray route_done / stall that must be ignored.
    step(0, 0, 0, $urandom % 2, $urandom % 2, 0, 1, 1);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    // Two full sweeps of 4,5,6 then routers satisfied.
    run_tile(4, 3, 7, 0, -1);
    // Empty tile goes straight to done.
    run_tile($urandom % 64, 0, -1, 0, -1);
    // Routers never satisfied: sweep limit abort.
    run_tile($urandom % 64, 2, -1, 0, -1);
    // New start clears the sticky timeout.
    run_tile(10, 5, 6, 0, -1);
    // Stalls mid-sweep with reads in flight.
    run_tile(20, 5, -1, 30, -1);
    // Address wrap across the top of the SRAM.
    run_tile(62, 4, 9, 0, -1);
    // Clear mid-sweep with reads in flight.
    run_tile(30, 6, -1, 0, 5);
    // Reset mid-sweep behaves like clear.
    step(1, 8, 5, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    // Random tiles.
    for (int t = 0; t < 10; t++) begin
      run_tile($urandom % 64, $urandom % 8, ($urandom % 3 == 0) ? -1 : int'($urandom % 20),
               $urandom % 40, ($urandom % 6 == 0) ? int'(1 + $urandom % 8) : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
